// File: rtl/mem_arbiter.sv
// Two-port block-burst memory arbiter: I-cache and D-cache share one main memory.
// Optional ARB_ROUND_ROBIN_EN: alternate preference on contention instead of D-over-I.
module mem_arbiter #(
  parameter int unsigned c_block_size = 2,
  parameter int unsigned c_line_size  = 64,
  parameter int unsigned address_size = 32
) (
  input  logic                                            arb_clk_i,
  input  logic                                            arb_reset_i,

  input  logic                                            i_read_i,
  input  logic                                            i_wr_i,
  input  logic [address_size-c_block_size-3:0]            i_addr_i,
  input  logic [(2**c_block_size)*c_line_size-1:0]        i_wr_data_i,
  output logic                                            i_busywait_o,
  output logic [(2**c_block_size)*c_line_size-1:0]        i_read_data_o,
  output logic                                            i_done_o,

  input  logic                                            d_read_i,
  input  logic                                            d_wr_i,
  input  logic [address_size-c_block_size-3:0]            d_addr_i,
  input  logic [(2**c_block_size)*c_line_size-1:0]        d_wr_data_i,
  output logic                                            d_busywait_o,
  output logic [(2**c_block_size)*c_line_size-1:0]        d_read_data_o,
  output logic                                            d_done_o,

  output logic                                            m_read_o,
  output logic                                            m_wr_o,
  output logic [address_size-c_block_size-3:0]            m_addr_o,
  output logic [(2**c_block_size)*c_line_size-1:0]        m_wr_data_o,
  input  logic                                            m_busywait_i,
  input  logic [(2**c_block_size)*c_line_size-1:0]        m_read_data_i,
  input  logic                                            m_read_done_i,
  input  logic                                            m_write_done_i
);

  localparam int unsigned AW = address_size - c_block_size - 2;
  localparam int unsigned BW = (2**c_block_size) * c_line_size;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  state_t          state;
  logic            i_grant_q;
  logic            d_grant_q;
  logic            op_wr_q;
  logic [AW-1:0]   addr_q;
  logic [BW-1:0]   wdata_q;

  logic            i_req;
  logic            d_req;
  logic            prefer_d;
  logic            pick_d;
  logic            in_service;
  logic            done_hit;
  logic            unused_mem_busy;

  assign unused_mem_busy = m_busywait_i;

  assign i_req = i_read_i | i_wr_i;
  assign d_req = d_read_i | d_wr_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr_d;
  assign prefer_d = rr_ptr_d;
`else
  assign prefer_d = 1'b1;
`endif

  assign pick_d     = d_req & (prefer_d | ~i_req);
  assign in_service = (state == ISSUE) | (state == WAIT);
  // Only the completion pulse matching the latched op ends the transaction.
  assign done_hit   = op_wr_q ? m_write_done_i : m_read_done_i;

  assign i_busywait_o = (i_req | (i_grant_q & in_service)) & ~i_done_o;
  assign d_busywait_o = (d_req | (d_grant_q & in_service)) & ~d_done_o;

  always_ff @(posedge arb_clk_i or posedge arb_reset_i) begin
    if (arb_reset_i) begin
      state         <= IDLE;
      i_grant_q     <= 1'b0;
      d_grant_q     <= 1'b0;
      op_wr_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      m_read_o      <= 1'b0;
      m_wr_o        <= 1'b0;
      m_addr_o      <= '0;
      m_wr_data_o   <= '0;
      i_read_data_o <= '0;
      d_read_data_o <= '0;
      i_done_o      <= 1'b0;
      d_done_o      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_d      <= 1'b1;
`endif
    end else begin
      i_done_o <= 1'b0;
      d_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            i_grant_q <= ~pick_d;
            d_grant_q <= pick_d;
            op_wr_q   <= pick_d ? ~d_read_i : ~i_read_i;
            addr_q    <= pick_d ? d_addr_i : i_addr_i;
            wdata_q   <= pick_d ? d_wr_data_i : i_wr_data_i;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          m_read_o    <= ~op_wr_q;
          m_wr_o      <= op_wr_q;
          m_addr_o    <= addr_q;
          m_wr_data_o <= wdata_q;
          state       <= WAIT;
        end
        WAIT: begin
          if (done_hit) begin
            m_read_o <= 1'b0;
            m_wr_o   <= 1'b0;
            if (!op_wr_q) begin
              if (d_grant_q) d_read_data_o <= m_read_data_i;
              else           i_read_data_o <= m_read_data_i;
            end
            i_done_o <= i_grant_q;
            d_done_o <= d_grant_q;
            state    <= RELEASE;
          end
        end
        RELEASE: begin
          // Requests stay low for this cycle so memory cannot re-launch the finished burst.
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_d  <= i_grant_q;
`endif
          i_grant_q <= 1'b0;
          d_grant_q <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 4-beat burst memory.
module tb_mem_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned BW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_read_i = 1'b0, i_wr_i = 1'b0;
  logic [AW-1:0] i_addr_i = '0;
  logic [BW-1:0] i_wr_data_i = '0;
  logic          i_busywait_o, i_done_o;
  logic [BW-1:0] i_read_data_o;
  logic          d_read_i = 1'b0, d_wr_i = 1'b0;
  logic [AW-1:0] d_addr_i = '0;
  logic [BW-1:0] d_wr_data_i = '0;
  logic          d_busywait_o, d_done_o;
  logic [BW-1:0] d_read_data_o;
  logic          m_read_o, m_wr_o;
  logic [AW-1:0] m_addr_o;
  logic [BW-1:0] m_wr_data_o;
  logic          m_busywait_i;
  logic [BW-1:0] m_read_data_i = '0;
  logic          m_read_done_i = 1'b0, m_write_done_i = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.c_block_size(2), .c_line_size(64), .address_size(32)) dut (
    .arb_clk_i(clk), .arb_reset_i(rst),
    .i_read_i(i_read_i), .i_wr_i(i_wr_i), .i_addr_i(i_addr_i), .i_wr_data_i(i_wr_data_i),
    .i_busywait_o(i_busywait_o), .i_read_data_o(i_read_data_o), .i_done_o(i_done_o),
    .d_read_i(d_read_i), .d_wr_i(d_wr_i), .d_addr_i(d_addr_i), .d_wr_data_i(d_wr_data_i),
    .d_busywait_o(d_busywait_o), .d_read_data_o(d_read_data_o), .d_done_o(d_done_o),
    .m_read_o(m_read_o), .m_wr_o(m_wr_o), .m_addr_o(m_addr_o), .m_wr_data_o(m_wr_data_o),
    .m_busywait_i(m_busywait_i), .m_read_data_i(m_read_data_i),
    .m_read_done_i(m_read_done_i), .m_write_done_i(m_write_done_i)
  );

  always #5 clk = ~clk;

  // Burst memory: start cycle, 4 beats, then a one-cycle done phase; not reset by rst.
  logic [63:0]   mem [0:255];
  logic [1:0]    mph = 2'd0;
  logic [1:0]    mcnt = 2'd0;
  logic          mwr = 1'b0;
  logic [AW-1:0] maddr = '0;
  logic [BW-1:0] mwdata = '0;

  initial for (int k = 0; k < 256; k++) mem[k] = {32'hC0DE0000, 24'h0, 8'(k)};

  assign m_busywait_i = (mph != 2'd0);

  always @(posedge clk) begin
    m_read_done_i  <= 1'b0;
    m_write_done_i <= 1'b0;
    case (mph)
      2'd0: if (m_read_o || m_wr_o) begin
        mph <= 2'd1; mcnt <= 2'd0; mwr <= !m_read_o; maddr <= m_addr_o; mwdata <= m_wr_data_o;
      end
      2'd1: begin
        mcnt <= mcnt + 2'd1;
        if (mcnt == 2'd3) begin
          mph <= 2'd2;
          if (mwr) begin
            m_write_done_i <= 1'b1;
            for (int j = 0; j < 4; j++) mem[{maddr[5:0], 2'(j)}] <= mwdata[j*64 +: 64];
          end else begin
            m_read_done_i <= 1'b1;
            for (int j = 0; j < 4; j++) m_read_data_i[j*64 +: 64] <= mem[{maddr[5:0], 2'(j)}];
          end
        end
      end
      default: mph <= 2'd0;
    endcase
  end

  // Counts memory bursts and the idle gap preceding the latest one.
  int   rises = 0, last_gap = 0, gap = 0;
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if ((m_read_o || m_wr_o) && !prev_req) begin
      rises    <= rises + 1;
      last_gap <= gap;
    end
    gap      <= (m_read_o || m_wr_o) ? 0 : gap + 1;
    prev_req <= m_read_o || m_wr_o;
  end

  function automatic logic [BW-1:0] exp_blk(input logic [AW-1:0] a);
    logic [BW-1:0] r;
    for (int j = 0; j < 4; j++) r[j*64 +: 64] = {32'hC0DE0000, 24'h0, a[5:0], 2'(j)};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  bit track_ibusy = 1'b0, track_wdata = 1'b0;
  int ibusy_low = 0, wdata_bad = 0;

  task automatic step();
    @(negedge clk);
    #1;
    if (track_ibusy && !i_busywait_o && !i_done_o) ibusy_low++;
    if (track_wdata && m_wr_o && m_wr_data_o !== {4{64'hAAAA_AAAA_AAAA_AAAA}}) wdata_bad++;
  endtask

  task automatic wait_done(input bit is_d, input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      step();
      seen = is_d ? d_done_o : i_done_o;
    end
    chk(tag, 256'(seen), 256'(1'b1));
  endtask

  task automatic pulse_reset();
    rst = 1'b1; step(); rst = 1'b0; step();
  endtask

  logic [7:0] seq;
  int         r0;
  bit         got;

  initial begin
    // Reset state
    rst = 1'b1;
    step(); step();
    chk("rst_ctrl", 256'({i_busywait_o, i_done_o, d_busywait_o, d_done_o, m_read_o, m_wr_o}), '0);
    chk("rst_maddr", 256'(m_addr_o), '0);
    chk("rst_mwdata", m_wr_data_o, '0);
    chk("rst_irdata", i_read_data_o, '0);
    chk("rst_drdata", d_read_data_o, '0);
    rst = 1'b0;
    step();

    // Single D read of block 0x10
    d_read_i = 1'b1; d_addr_i = 28'h0000010;
    step();
    chk("t1_dbusy", 256'(d_busywait_o), 256'(1'b1));
    step();
    chk("t1_mread", 256'(m_read_o), 256'(1'b1));
    chk("t1_mwr", 256'(m_wr_o), '0);
    chk("t1_maddr", 256'(m_addr_o), 256'(28'h0000010));
    wait_done(1'b1, "t1_ddone_timeout");
    chk("t1_drdata", d_read_data_o,
        256'hC0DE0000_00000043_C0DE0000_00000042_C0DE0000_00000041_C0DE0000_00000040);
    chk("t1_dbusy_done", 256'(d_busywait_o), '0);
    chk("t1_iside", 256'({i_busywait_o, i_done_o}), '0);
    chk("t1_irdata", i_read_data_o, '0);
    d_read_i = 1'b0;
    step();
    chk("t1_dpulse", 256'(d_done_o), '0);

    // Single I write of 0xAAAA... to block 0x20, then D reads it back
    i_wr_i = 1'b1; i_addr_i = 28'h0000020; i_wr_data_i = {4{64'hAAAA_AAAA_AAAA_AAAA}};
    step(); step();
    chk("t2_mwr", 256'({m_wr_o, m_read_o}), 256'(2'b10));
    chk("t2_maddr", 256'(m_addr_o), 256'(28'h0000020));
    chk("t2_mwdata", m_wr_data_o, {4{64'hAAAA_AAAA_AAAA_AAAA}});
    track_wdata = 1'b1;
    wait_done(1'b0, "t2_idone_timeout");
    track_wdata = 1'b0;
    i_wr_i = 1'b0;
    chk("t2_wdata_stable", 256'(wdata_bad), '0);
    chk("t2_ddone_quiet", 256'(d_done_o), '0);
    step();
    chk("t2_ipulse", 256'(i_done_o), '0);
    chk("t2_irdata_kept", i_read_data_o, '0);
    d_read_i = 1'b1; d_addr_i = 28'h0000020;
    wait_done(1'b1, "t2_rb_timeout");
    chk("t2_readback", d_read_data_o, {4{64'hAAAA_AAAA_AAAA_AAAA}});
    d_read_i = 1'b0;
    step();

    // Simultaneous I and D reads: D first, I held busy, two separated bursts
    pulse_reset();
    r0 = rises;
    d_read_i = 1'b1; d_addr_i = 28'h0000010;
    i_read_i = 1'b1; i_addr_i = 28'h0000011;
    track_ibusy = 1'b1;
    step(); step();
    chk("t3_first_d", 256'(m_addr_o), 256'(28'h0000010));
    wait_done(1'b1, "t3_ddone_timeout");
    d_read_i = 1'b0;
    wait_done(1'b0, "t3_idone_timeout");
    i_read_i = 1'b0;
    track_ibusy = 1'b0;
    chk("t3_irdata", i_read_data_o, exp_blk(28'h0000011));
    chk("t3_drdata_kept", d_read_data_o, exp_blk(28'h0000010));
    chk("t3_ibusy_held", 256'(ibusy_low), '0);
    chk("t3_bursts", 256'(rises - r0), 256'(2));
    chk("t3_gap", 256'(last_gap >= 1), 256'(1'b1));
    step();

    // Both ports requesting continuously for four transactions
    pulse_reset();
    d_read_i = 1'b1; d_addr_i = 28'h0000010;
    i_read_i = 1'b1; i_addr_i = 28'h0000011;
    seq = '0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
        step();
        if (d_done_o)      begin seq[k*2 +: 2] = 2'd2; got = 1'b1; end
        else if (i_done_o) begin seq[k*2 +: 2] = 2'd1; got = 1'b1; end
      end
    end
`ifdef ARB_ROUND_ROBIN_EN
    chk("t4_grant_order", 256'(seq), 256'(8'h66));
`else
    chk("t4_grant_order", 256'(seq), 256'(8'hAA));
`endif
    d_read_i = 1'b0; i_read_i = 1'b0;
    step(); step(); step();

    // D drops and retargets its request mid-WAIT
    d_read_i = 1'b1; d_addr_i = 28'h0000012;
    step(); step(); step(); step();
    d_read_i = 1'b0; d_addr_i = 28'h0000030;
    step();
    chk("t5_maddr_held", 256'(m_addr_o), 256'(28'h0000012));
    chk("t5_mread_held", 256'(m_read_o), 256'(1'b1));
    chk("t5_dbusy_owner", 256'(d_busywait_o), 256'(1'b1));
    wait_done(1'b1, "t5_ddone_timeout");
    chk("t5_drdata", d_read_data_o, exp_blk(28'h0000012));
    step();

    // Asynchronous reset during WAIT, then a fresh I read
    i_read_i = 1'b1; i_addr_i = 28'h0000013;
    step(); step(); step(); step();
    rst = 1'b1; i_read_i = 1'b0;
    #1;
    chk("t6_ctrl", 256'({i_busywait_o, i_done_o, d_busywait_o, d_done_o, m_read_o, m_wr_o}), '0);
    chk("t6_maddr", 256'(m_addr_o), '0);
    chk("t6_rdata", i_read_data_o | d_read_data_o | m_wr_data_o, '0);
    step();
    rst = 1'b0;
    for (int n = 0; n < 12; n++) step();
    i_read_i = 1'b1; i_addr_i = 28'h0000014;
    wait_done(1'b0, "t6_idone_timeout");
    chk("t6_irdata", i_read_data_o, exp_blk(28'h0000014));
    i_read_i = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter sharing the single block-burst main memory between the instruction cache (port I) and the data cache (port D).
- Accepts block-granular read/write requests from each cache and grants one at a time.
- Drives the memory request/address/data lines and routes read data and completion pulses back to the winner.
- Sits between both cache controllers and the memory model; neither cache connects to memory directly.

Parameters:
- c_block_size, 2, log2 of memory words per cache block (beats per burst).
- c_line_size, 64, bits per cache word; block width BW = 2**c_block_size*c_line_size (256).
- address_size, 32, byte address width; block address width AW = address_size - c_block_size - 2 (28).

Ports:
- arb_clk_i  in  1  single clock, rising edge.
- arb_reset_i  in  1  asynchronous, active-high reset.
- i_read_i / i_wr_i  in  1 each  I-cache read / write-back request.
- i_addr_i  in  AW  I-cache block address.
- i_wr_data_i  in  BW  I-cache write block.
- i_busywait_o  out  1  I request pending or in service.
- i_read_data_o  out  BW  block returned to I.
- i_done_o  out  1  one-cycle completion pulse to I.
- d_read_i, d_wr_i, d_addr_i, d_wr_data_i, d_busywait_o, d_read_data_o, d_done_o  same as the I-port signals, for the D-cache.
- m_read_o / m_wr_o  out  1 each  memory read / write request.
- m_addr_o  out  AW  memory block address.
- m_wr_data_o  out  BW  memory write block.
- m_busywait_i  in  1  memory busy.
- m_read_data_i  in  BW  memory read block.
- m_read_done_i / m_write_done_i  in  1 each  memory completion pulses.

Behaviour:
- Reset (async): state IDLE; every output 0, including read-data registers and the grant register; the round-robin pointer points at D. Any in-flight transaction is dropped and the requester must reissue.
- A port requests when read_i|wr_i. If both are set on one port, read wins, matching memory priority.
- States and transitions:
  - IDLE: no request -> stay. Otherwise pick a winner (fixed priority: D over I), latch owner, op, address and write data, then -> ISSUE.
  - ISSUE: registered m_read_o/m_wr_o, m_addr_o and m_wr_data_o go high/valid from this edge; -> WAIT.
  - WAIT: hold the memory outputs stable. On the edge sampling m_read_done_i (read) or m_write_done_i (write): clear m_read_o/m_wr_o, capture m_read_data_i into the owner's read_data_o (reads only), pulse owner done_o for exactly one cycle, -> RELEASE.
  - RELEASE: one cycle with memory requests low, so the memory's IDLE cannot restart a burst; -> IDLE.
- The non-owner's read_data_o is never modified.
- busywait_o is combinational: a port's busywait is high when it requests, or when it owns a transaction in ISSUE/WAIT; low on the cycle its done_o is high. A losing requester stays busy until served.
- Latched address, data and op are used for the whole transaction. A requester that changes or drops its request mid-transaction does not abort it; done_o is still issued.
- m_busywait_i is informational only. A done pulse of the wrong type (e.g. write_done during a read) is ignored.
- Minimum latency request -> done_o: 1 (grant) + 1 (issue) + memory burst (2**c_block_size beats + done cycle) edges. Back-to-back: the next grant occurs in IDLE after RELEASE, so at least 1 idle cycle separates memory transactions.
- Both ports requesting in the same IDLE cycle: exactly one grant, never both. The loser is served next, because after RELEASE only the loser is requesting (or the pointer favours it).

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - 1-bit pointer names the preferred port; it flips to the non-owner after each RELEASE.
  - On simultaneous requests the preferred port wins; the first contested grant after reset goes to D.
- Undefined: fixed priority, D always beats I; the pointer logic is absent.

Test Plan:
- Single D read at addr 0x0000010, I idle -> m_read_o high from ISSUE with m_addr_o=0x0000010; d_read_data_o equals memory words 0x40..0x43 packed LSW-first; one-cycle d_done_o; i_* outputs remain 0.
- Single I write of 0xAAAA..., addr 0x0000020 -> m_wr_o asserted, m_wr_data_o stable through WAIT; i_done_o pulses once; a later D read of 0x0000020 returns 0xAAAA....
- I and D read in the same cycle, fixed priority -> D served first, I busywait held high throughout, then I served; exactly two memory bursts, separated by at least 1 idle cycle.
- Same as previous with ARB_ROUND_ROBIN_EN, both ports requesting continuously for 4 transactions -> grants alternate D, I, D, I.
- D read in flight, D drops d_read_i and changes d_addr_i mid-WAIT -> m_addr_o unchanged, d_done_o still pulses, data from original address.
- arb_reset_i asserted during WAIT -> all outputs 0 immediately (asynchronously); after release and memory idle, a fresh I read completes normally.
